// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the ordered reset-release sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_DONE
  } rst_seq_state_e;

  // Wide enough to hold the larger of the hold length and the ack timeout.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned ato);
    int unsigned m;
    m = (hold > ato) ? hold : ato;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of sequencer control/status signals; slave side is the sequencer itself.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_DOM)
);

  logic               sw_rst_req;
  logic [NUM_DOM-1:0] dom_ack;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               seq_busy;
  logic               seq_done;
  logic               timeout_err;
  logic [IDX_W-1:0]   err_dom;

  modport slave (
    input  sw_rst_req,
    input  dom_ack,
    output dom_rst_n,
    output seq_busy,
    output seq_done,
    output timeout_err,
    output err_dom
  );

  modport master (
    output sw_rst_req,
    output dom_ack,
    input  dom_rst_n,
    input  seq_busy,
    input  seq_done,
    input  timeout_err,
    input  err_dom
  );

endinterface

// File: rtl/reset_seq_timer.sv
// Clearable up-counter with a combinational terminal-count compare.
module reset_seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc_o_c = (cnt_q == tc_val_i);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOM reset domains in index order, each gated by its ready ack.
// Optional per-domain ack timeout is built when RST_SEQ_TIMEOUT_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   bus
);

  localparam int unsigned IDX_W = idx_width(NUM_DOM);
  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);

  rst_seq_state_e     state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] rstn_q, rstn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef RST_SEQ_TIMEOUT_EN
  logic               terr_q, terr_d;
  logic [IDX_W-1:0]   err_dom_q, err_dom_d;
`endif

  logic               tmr_clr;
  logic               tmr_inc;
  logic [CNT_W-1:0]   tmr_tc_val;
  logic               tmr_tc;
  logic               advance;

  reset_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .tc_val_i (tmr_tc_val),
    .tc_o_c   (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      idx_q     <= '0;
      rstn_q    <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      terr_q    <= 1'b0;
      err_dom_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rstn_q    <= rstn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef RST_SEQ_TIMEOUT_EN
      terr_q    <= terr_d;
      err_dom_q <= err_dom_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rstn_d     = rstn_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
    terr_d     = terr_q;
    err_dom_d  = err_dom_q;
`endif
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    tmr_tc_val = CNT_W'(HOLD_CYCLES - 1);
    advance    = 1'b0;

    case (state_q)
      ST_ASSERT: begin
        rstn_d  = '0;
        tmr_inc = 1'b1;
        if (tmr_tc) begin
          state_d = ST_WAIT_ACK;
          idx_d   = '0;
          rstn_d  = NUM_DOM'(1);
          tmr_clr = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        advance = bus.dom_ack[idx_q];
`ifdef RST_SEQ_TIMEOUT_EN
        // A late ack on the terminal cycle still wins over the timeout.
        tmr_tc_val = CNT_W'(ACK_TIMEOUT - 1);
        tmr_inc    = !advance;
        if (!advance && tmr_tc) begin
          advance = 1'b1;
          terr_d  = 1'b1;
          if (!terr_q) begin
            err_dom_d = idx_q;
          end
        end
`endif
        if (advance) begin
          tmr_clr = 1'b1;
          if (idx_q == IDX_W'(NUM_DOM - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rstn_d  = '1;
          end else begin
            idx_d         = idx_q + IDX_W'(1);
            rstn_d[idx_d] = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (bus.sw_rst_req) begin
          state_d   = ST_ASSERT;
          idx_d     = '0;
          rstn_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          tmr_clr   = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
          terr_d    = 1'b0;
          err_dom_d = '0;
`endif
        end
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign bus.dom_rst_n   = rstn_q;
  assign bus.seq_busy    = busy_q;
  assign bus.seq_done    = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.timeout_err = terr_q;
  assign bus.err_dom     = err_dom_q;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.err_dom     = '0;
`endif

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Ordered reset-release controller for the chip's reset domains. Runs in the clock domain of the reset synchronizer, after the asynchronous reset has been synchronized. Holds all downstream domains in reset, then releases them one at a time in index order. Each domain must acknowledge readiness before the next is released. Supports a software-requested re-sequence.

## Interface
Parameters:
- NUM_DOM, 4, number of reset domains; legal range 2..16.
- HOLD_CYCLES, 16, cycles all domains are held in reset before the first release; must be ≥1.
- ACK_TIMEOUT, 255, maximum WAIT_ACK cycles per domain; only used with the timeout feature; must be ≥1.

Ports:
- clk  in  1  single clock; one clock.
- rst  in  1  reset, synchronous and active-high.
- sw_rst_req  in  1  request to re-run the full sequence; level-sampled.
- dom_ack  in  NUM_DOM  per-domain ready acknowledge; bit i is meaningful only while waiting on domain i.
- dom_rst_n  out  NUM_DOM  per-domain active-low reset, registered.
- seq_busy  out  1  sequence in progress.
- seq_done  out  1  all domains released.
- timeout_err  out  1  sticky flag: some domain's ack timed out.
- err_dom  out  IDX_W  index of the first domain that timed out.

## Operation
- Width rules:
  - IDX_W = max(1, $clog2(NUM_DOM)).
  - Counter width = $clog2(max(HOLD_CYCLES, ACK_TIMEOUT)+1).
- Reset values while rst=1: dom_rst_n all 0, seq_busy=1, seq_done=0, timeout_err=0, err_dom=0, state ST_ASSERT, idx=0, counter=0.
- ST_ASSERT:
  - All dom_rst_n are 0 and the counter increments each cycle.
  - When the counter reaches HOLD_CYCLES-1, go to ST_WAIT_ACK with idx=0 and set dom_rst_n[0]=1.
- ST_WAIT_ACK(idx):
  - dom_rst_n[0..idx] are 1; higher bits are 0.
  - If dom_ack[idx]=1 and idx<NUM_DOM-1: idx+1, set dom_rst_n[idx+1], clear the counter.
  - If dom_ack[idx]=1 and idx=NUM_DOM-1: go to ST_DONE.
- ST_DONE: seq_busy=0, seq_done=1, all dom_rst_n are 1.
- Software request in ST_DONE:
  - sw_rst_req=1 sends the block to ST_ASSERT next cycle.
  - All dom_rst_n drop to 0 simultaneously.
  - The counter clears, timeout_err and err_dom clear, seq_busy=1, seq_done=0.
- sw_rst_req is ignored outside ST_DONE; it is not queued.
- dom_ack bits are ignored:
  - for domains not yet released;
  - for domains already passed, including later deassertion.
- rst=1 in any state or cycle: all registers return to their reset values next cycle, and the sequence restarts from ST_ASSERT.

## Timing
- Cycle 0 is the first cycle with rst=0.
- dom_rst_n[0] first goes high in cycle HOLD_CYCLES.
- Minimum of 1 cycle per domain. If dom_ack[i] is sampled high in cycle k, dom_rst_n[i+1] is high in cycle k+1.
- The ack may already be high in the first cycle dom_rst_n[i] is high; it counts in that cycle.
- seq_done and !seq_busy are asserted in the cycle after the last ack is sampled.
- From a sw_rst_req accepted in cycle d:
  - dom_rst_n goes to 0 in cycle d+1;
  - dom_rst_n[0] goes high in cycle d+1+HOLD_CYCLES.

## Configuration
- Macro RST_SEQ_TIMEOUT_EN defined (timeout enabled):
  - In ST_WAIT_ACK the counter counts cycles with dom_ack[idx]=0.
  - If ACK_TIMEOUT consecutive cycles pass without an ack, then next cycle: timeout_err=1, and the sequence proceeds as if the ack had arrived.
  - err_dom is written only if timeout_err was 0, so it holds the first failing index.
  - If the ack arrives in the same cycle the timeout would fire, the ack wins and no error is flagged.
- Macro undefined:
  - WAIT_ACK waits indefinitely.
  - timeout_err and err_dom are tied to 0.
  - ACK_TIMEOUT is unused.

## Structure
- reset_seq_pkg holds:
  - typedef enum rst_seq_state_e {ST_ASSERT, ST_WAIT_ACK, ST_DONE};
  - the function computing the counter width.
- One sub-module, reset_seq_timer: a clearable up-counter with a terminal-count compare. It is shared between the hold phase and the ack-timeout phase.
- The FSM, idx register and output registers live in reset_sequencer.

## Test plan
- Defaults with dom_ack tied to all 1s:
  - Release rst at cycle 0.
  - Expect dom_rst_n = 0001 at cycle 16, 0011 at 17, 0111 at 18, 1111 at 19.
  - Expect seq_done=1 at cycle 20.
- Delayed ack: dom_ack[1] rises in cycle 30.
  - Expect dom_rst_n[2]=1 in cycle 31.
  - Expect dom_rst_n[3]=0 before cycle 31.
- sw_rst_req pulse at cycle 40 after done:
  - Expect all dom_rst_n=0 at cycle 41 and dom_rst_n[0]=1 at cycle 57.
  - A second pulse at cycle 45 is ignored.
- Mid-sequence rst: assert rst at cycle 17 for 1 cycle.
  - Expect outputs at reset values in cycle 18.
  - Expect dom_rst_n[0] to re-rise 16 cycles after rst drops.
- RST_SEQ_TIMEOUT_EN with ACK_TIMEOUT=8, dom_ack[2] stuck at 0:
  - Expect timeout_err=1 and err_dom=2 eight cycles after dom_rst_n[2] rises.
  - Expect dom_rst_n[3]=1 in the same cycle.
  - Expect seq_done to follow.
- Ack and timeout coincide, with ACK_TIMEOUT=8 and dom_ack[1] high exactly on the 8th waiting cycle: expect timeout_err=0.
